// File: rtl/seg7_pkg.sv
// Shared segment constants, hex font and FSM state type for the seven-segment controller.
package seg7_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    // Active-high forms; the top applies output polarity last.
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;
    localparam logic [6:0] SEG_DASH  = 7'(1 << SEG_G);

    typedef enum logic [0:0] {IDLE, CONV} state_e;

    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-and-add-3 step per cycle, 4*NUM_DIGITS steps.
module bin2bcd_seq #(
    parameter int unsigned NUM_DIGITS = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [4*NUM_DIGITS-1:0] bin_i,
    output logic                    done_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o
);

    localparam int unsigned W    = 4 * NUM_DIGITS;
    localparam int unsigned CNTW = $clog2(W);
    localparam logic [CNTW-1:0] LAST = CNTW'(W - 1);

    logic [W-1:0]    bin_q;
    logic [W-1:0]    bcd_q;
    logic [CNTW-1:0] cnt_q;
    logic            run_q;
    logic [W-1:0]    adj;
    logic [2*W-1:0]  shifted;

    always_comb begin
        adj = bcd_q;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        shifted = {adj, bin_q} << 1;
    end

    // bcd_o is the result of the step in flight; it is the final value while done_o is high.
    assign bcd_o  = shifted[2*W-1:W];
    assign done_o = run_q && (cnt_q == LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            bin_q <= bin_i;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            bin_q <= shifted[W-1:0];
            bcd_q <= shifted[2*W-1:W];
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Multi-digit seven-segment controller: hex/decimal load handshake, leading-zero blanking,
// per-digit blink and decimal overflow dashes.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned BLINK_DIV  = 25_000_000,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] in_value,
    input  logic                    in_dec,
    input  logic                    in_blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic                    overflow,
    output logic                    busy
);

    localparam int unsigned W   = 4 * NUM_DIGITS;
    localparam int unsigned BCW = $clog2(BLINK_DIV);
    localparam longint unsigned DEC_MAX = pow10(NUM_DIGITS) - 1;

    state_e                state_q;
    logic [W-1:0]          digits_q;
    logic [NUM_DIGITS-1:0] blank_q;
    logic                  ovf_q;
    logic                  lz_q;
    logic [BCW-1:0]        blink_cnt_q;
    logic                  blink_ph_q;

    logic                  dec_over;
    logic                  conv_start;
    logic                  conv_done;
    logic [W-1:0]          conv_bcd;

    // Blank every digit above the most significant non-zero one; digit 0 always shows.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [W-1:0] d);
        logic [NUM_DIGITS-1:0] mask;
        logic                  seen;
        mask = '0;
        seen = 1'b0;
        for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
            seen    = seen | (d[4*k +: 4] != 4'h0);
            mask[k] = ~seen;
        end
        return mask;
    endfunction

    function automatic logic [6:0] digit_glyph(input logic [3:0] nib, input logic dash,
                                               input logic off);
        logic [6:0] g;
        g = off ? SEG_BLANK : (dash ? SEG_DASH : hex_font(nib));
        return (ACTIVE_LOW != 0) ? ~g : g;
    endfunction

    assign in_ready   = (state_q == IDLE);
    assign busy       = ~in_ready;
    assign overflow   = ovf_q;
    assign dec_over   = 64'(in_value) > DEC_MAX;
    assign conv_start = in_ready && in_valid && in_dec && !dec_over;

    bin2bcd_seq #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_bin2bcd (
        .clk_i  (clk),
        .rst_i  (rst),
        .start_i(conv_start),
        .bin_i  (in_value),
        .done_o (conv_done),
        .bcd_o  (conv_bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            digits_q <= '0;
            blank_q  <= '1;
            ovf_q    <= 1'b0;
            lz_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (!in_dec) begin
                            digits_q <= in_value;
                            blank_q  <= in_blank_lz ? lz_mask(in_value) : '0;
                            ovf_q    <= 1'b0;
                        end else if (dec_over) begin
                            blank_q <= '0;
                            ovf_q   <= 1'b1;
                        end else begin
                            lz_q    <= in_blank_lz;
                            state_q <= CONV;
                        end
                    end
                end
                CONV: begin
                    if (conv_done) begin
                        digits_q <= conv_bcd;
                        blank_q  <= lz_q ? lz_mask(conv_bcd) : '0;
                        ovf_q    <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else if (blink_cnt_q == BCW'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= ~blink_ph_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    always_comb begin
        seg_out = '0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            seg_out[7*k +: 7] = digit_glyph(digits_q[4*k +: 4], ovf_q,
                                            blank_q[k] | (blink_ph_q & blink_mask[k]));
        end
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl (4 digits, BLINK_DIV = 4, active-low segments).
module tb_seg7_display_ctrl;

    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [6:0] OFF  = 7'h7F;
    localparam logic [6:0] DASH = 7'h3F;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_dec = 1'b0;
    logic        in_blank_lz = 1'b0;
    logic [15:0] in_value = '0;
    logic [3:0]  blink_mask = '0;
    logic        in_ready;
    logic        overflow;
    logic        busy;
    logic [27:0] seg_out;

    int passed = 0;
    int total = 0;

    typedef struct {
        string       tag;
        logic [27:0] seg;
        logic        ovf;
    } exp_t;
    exp_t        sb[$];
    logic [27:0] held_seg;

    int unsigned bcnt;
    logic        bph;

    always #5 clk = ~clk;

    seg7_display_ctrl #(
        .NUM_DIGITS(4),
        .BLINK_DIV (4),
        .ACTIVE_LOW(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .in_dec     (in_dec),
        .in_blank_lz(in_blank_lz),
        .blink_mask (blink_mask),
        .seg_out    (seg_out),
        .overflow   (overflow),
        .busy       (busy)
    );

    // Reference blink phase: toggles every 4 cycles after reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt <= 0;
            bph  <= 1'b0;
        end else if (bcnt == 3) begin
            bcnt <= 0;
            bph  <= ~bph;
        end else begin
            bcnt <= bcnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    function automatic void model(input logic [15:0] v, input logic dec, input logic lz,
                                  output logic [27:0] seg, output logic ovf);
        int unsigned d[4];
        int unsigned p;
        int          top;
        seg = '0;
        if (dec && v > 16'd9999) begin
            seg = {4{DASH}};
            ovf = 1'b1;
            return;
        end
        ovf = 1'b0;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            d[k] = dec ? (int'(v) / p) % 10 : (int'(v) >> (4 * k)) & 15;
            p = p * 10;
        end
        top = 0;
        for (int k = 0; k < 4; k++) begin
            if (d[k] != 0) top = k;
        end
        for (int k = 0; k < 4; k++) begin
            seg[7*k +: 7] = (lz && k > top) ? OFF : FONT[d[k]];
        end
    endfunction

    task automatic pop_check();
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_seg"}, seg_out, e.seg);
        check({e.tag, "_ovf"}, overflow, e.ovf);
        held_seg = e.seg;
    endtask

    // Drive one load; expect in_ready low for exp_cycles cycles with the old display held.
    task automatic load(input string tag, input logic [15:0] v, input logic dec, input logic lz,
                        input logic hold, input int exp_cycles);
        exp_t e;
        int   n;
        e.tag = tag;
        model(v, dec, lz, e.seg, e.ovf);
        sb.push_back(e);
        @(negedge clk);
        in_value    = v;
        in_dec      = dec;
        in_blank_lz = lz;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            check({tag, "_held"}, {busy, seg_out}, {1'b1, held_seg});
            n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check({tag, "_cycles"}, n, exp_cycles);
        pop_check();
        check({tag, "_ready"}, {in_ready, busy}, 2'b10);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("por_seg", seg_out, 28'hFFFFFFF);
        check("por_flags", {in_ready, overflow, busy}, 3'b100);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // Reset pulse while idle
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_seg", seg_out, 28'hFFFFFFF);
        check("rst_ready", in_ready, 1'b1);
        check("rst_ovf", overflow, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        held_seg = 28'hFFFFFFF;

        load("hex0a3f", 16'h0A3F, 1'b0, 1'b1, 1'b0, 0);
        load("dec1234", 16'd1234, 1'b1, 1'b0, 1'b0, 16);
        load("dec10000", 16'd10000, 1'b1, 1'b0, 1'b0, 0);
        load("hex0000", 16'h0000, 1'b0, 1'b1, 1'b0, 0);
        load("dec0_lz", 16'd0, 1'b1, 1'b1, 1'b0, 16);
        load("dec9999", 16'd9999, 1'b1, 1'b1, 1'b0, 16);

        // Blink on digit 0
        load("hex1111", 16'h1111, 1'b0, 1'b0, 1'b0, 0);
        blink_mask = 4'b0001;
        #1;
        for (int i = 0; i < 12; i++) begin
            check("blink", seg_out, {{3{7'h79}}, (bph ? OFF : 7'h79)});
            @(posedge clk);
            #1;
        end
        begin
            int n;
            n = 0;
            while (!bph && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("blink_phase_wait", n < 10, 1'b1);
        end
        check("blink_on_dark", seg_out, {{3{7'h79}}, OFF});
        blink_mask = 4'b0000;
        #1;
        check("blink_mask_off", seg_out, {4{7'h79}});

        // in_valid held across a conversion: exactly one accept
        load("dec907_hold", 16'd907, 1'b1, 1'b1, 1'b1, 16);

        // Reset mid-conversion aborts without commit
        @(negedge clk);
        in_value = 16'd4321;
        in_dec   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        repeat (7) @(posedge clk);
        #1;
        check("abort_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_seg", seg_out, 28'hFFFFFFF);
        check("abort_flags", {in_ready, overflow, busy}, 3'b100);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_nocommit", seg_out, 28'hFFFFFFF);
        check("abort_ready", in_ready, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
Parametrised multi-digit seven-segment display controller. It drives NUM_DIGITS static digit outputs from one wide value, in either hex mode or decimal mode. Decimal mode uses a sequential binary-to-BCD converter. The block adds leading-zero blanking, per-digit blink, overflow indication and a valid/ready load handshake. It sits between board-level control logic and the HEXn pins.

Parameters:
NUM_DIGITS, 6, number of digits; legal range 1..8.
BLINK_DIV, 25_000_000, clock cycles per blink half-period; must be >= 2.
ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (DE-board style); 0 = lit when bit is 1.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  load request
in_ready  out  1  block can accept a load
in_value  in  4*NUM_DIGITS  hex nibbles (hex mode) or unsigned binary (decimal mode)
in_dec  in  1  0 = hex mode, 1 = decimal mode; sampled on accept
in_blank_lz  in  1  leading-zero blanking enable; sampled on accept
blink_mask  in  NUM_DIGITS  per-digit blink enable; live, not latched
seg_out  out  7*NUM_DIGITS  digit k occupies bits [7k+6:7k]; bit0 = a … bit6 = g
overflow  out  1  last committed decimal value exceeded 10^NUM_DIGITS-1
busy  out  1  conversion in progress (equals ~in_ready)

Behaviour:
- Single clock domain. Reset is asynchronous and active-high; it is fixed to that polarity and synchronicity.
- Reset state:
  - FSM = IDLE; in_ready = 1; busy = 0; overflow = 0.
  - All digits blanked, so seg_out is all segments off: all-ones when ACTIVE_LOW = 1.
  - Blink counter = 0; blink phase = 0.
- Accept: a load is accepted on a rising edge where in_valid && in_ready. in_value, in_dec and in_blank_lz are latched on that edge. in_valid while busy is ignored; the caller must hold it.
- FSM:
  - IDLE: on accept with in_dec = 0, commit immediately and stay in IDLE.
  - IDLE: on accept with in_dec = 1 and in_value > 10^N-1, commit the overflow display immediately and stay in IDLE.
  - IDLE: otherwise, on accept go to CONV.
  - CONV: runs exactly 4*NUM_DIGITS cycles of shift-and-add-3 (double dabble) into N BCD digits. The commit happens on the edge that ends the last cycle, and the FSM returns to IDLE.
- Latency:
  - Hex and overflow cases: seg_out reflects the new value immediately after the accept edge.
  - Decimal case: in_ready is low for exactly 4*NUM_DIGITS cycles. The new display appears after accept edge + 4*NUM_DIGITS.
  - The previous display is held unchanged during CONV.
- Commit:
  - Loads the digit registers and the blank mask.
  - Sets overflow = 1 only for the decimal overflow case; clears it on every other commit.
- Overflow display: every digit shows a dash, i.e. segment g only. Blanking is not applied to dashes.
- Leading-zero blanking (in_blank_lz = 1): blank every digit above the most significant non-zero digit. Digit 0 is never blanked, so value 0 shows "0".
- Blink:
  - Free-running counter 0..BLINK_DIV-1; the blink phase toggles on wrap.
  - While phase = 1, every digit with its blink_mask bit set is blanked.
  - Blink applies on top of the blank mask and the dash display.
- Font: standard 0-F glyphs (a…g). Polarity is inverted when ACTIVE_LOW = 1. "Blank" means all segments off.
- seg_out is a pure function of registered state (digits, blank mask, overflow flag, blink phase) plus blink_mask. It never depends on in_value directly.
- Reset asserted mid-CONV aborts the conversion. Nothing is committed and the reset state applies.

Decomposition:
- Package seg7_pkg holds:
  - the segment bit-order constants;
  - SEG_BLANK and SEG_DASH (active-high form);
  - the 16-entry hex font as a function, nibble -> 7-bit active-high;
  - the FSM state typedef {IDLE, CONV}.
- Sub-module bin2bcd_seq is the sequential double-dabble engine, parametrised by NUM_DIGITS, with start/done.
- The top module holds the handshake, commit, blanking, blink and output polarity.

Test Plan (NUM_DIGITS=4, BLINK_DIV=4, ACTIVE_LOW=1):
1. Reset pulse mid-idle -> seg_out = 28'hFFFFFFF, in_ready = 1, overflow = 0, busy = 0.
2. Hex load 16'h0A3F, in_blank_lz = 1 -> after the accept edge: d3 = 7'h7F, d2 = 7'b0001000, d1 = 7'b0110000, d0 = 7'b0001110. in_ready stays 1.
3. Decimal load 16'd1234 -> in_ready low for exactly 16 cycles with the old display held. Then d3..d0 = 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001; overflow = 0.
4. Decimal load 16'd10000 -> immediately overflow = 1 and all digits 7'b0111111. Then hex load 16'h0000 with in_blank_lz = 1 -> d0 = 7'b1000000, d3..d1 = 7'h7F, overflow = 0.
5. blink_mask = 4'b0001 after a hex load of 16'h1111 -> d0 alternates 7'b1111001 / 7'h7F every 4 cycles. d3..d1 stay steady; mask change takes effect the same cycle.
6. Decimal load, then rst asserted on CONV cycle 8 with in_valid held -> display blanked and no commit. After release, in_ready = 1. Only one accept occurs across CONV, and no second accept happens while busy.
